// File: rtl/inv_shift_rows_serial.sv
// Serial InvShiftRows front end: collects four 32-bit rows per block, undoes the row
// rotation on the fly and presents a column-major 128-bit state from a ping-pong buffer pair.
module inv_shift_rows_serial #(
  parameter int NUM_BUF = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_row,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [1:0]   row_idx
);

  logic [127:0]       bufs [NUM_BUF];
  logic [NUM_BUF-1:0] full;
  logic               wr_ptr;
  logic               rd_ptr;
  logic [31:0]        shifted;
  logic [127:0]       lane_mask;
  logic [127:0]       lane_data;
  logic               wr_fire;
  logic               rd_fire;

  assign in_ready  = ~full[wr_ptr];
  assign out_valid = full[rd_ptr];
  assign out_state = bufs[rd_ptr];
  assign rd_fire   = out_valid & out_ready;
  assign wr_fire   = in_valid & in_ready & ~flush;

  // Output column c takes input column (c - r) mod 4.
  always_comb begin
    shifted = in_row;
    case (row_idx)
      2'd1:    shifted = {in_row[7:0],  in_row[31:8]};
      2'd2:    shifted = {in_row[15:0], in_row[31:16]};
      2'd3:    shifted = {in_row[23:0], in_row[31:24]};
      default: shifted = in_row;
    endcase
  end

  // Row r lands in byte (4c + r) of the column-major state for each column c.
  always_comb begin
    lane_mask = '0;
    lane_data = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (row_idx == 2'(r)) begin
          lane_mask[127-8*(4*c+r) -: 8] = 8'hff;
          lane_data[127-8*(4*c+r) -: 8] = shifted[31-8*c -: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BUF; i++) bufs[i] <= '0;
      full    <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      row_idx <= 2'd0;
    end else begin
      // A read frees the buffer it drains; a write only ever fills a non-full one,
      // so the two never touch the same flag in one cycle.
      if (rd_fire) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end
      if (flush) begin
        row_idx <= 2'd0;
      end else if (wr_fire) begin
        bufs[wr_ptr] <= (bufs[wr_ptr] & ~lane_mask) | lane_data;
        row_idx      <= row_idx + 2'd1;
        if (row_idx == 2'd3) begin
          full[wr_ptr] <= 1'b1;
          wr_ptr       <= ~wr_ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Directed bench for inv_shift_rows_serial: basic block, backpressure, back-to-back
// streaming, flush and asynchronous reset, with hand-computed expected states.
module tb_inv_shift_rows_serial;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_row;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [1:0]   row_idx;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] EXP_BASE = 128'h00132231_01102332_02112033_03122130;
  localparam logic [127:0] EXP_DEAD = 128'hde67cdfe_ad01eff0_be23890d_ef45abca;

  inv_shift_rows_serial #(.NUM_BUF(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .row_idx   (row_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Row r of the pattern block, every byte offset by k.
  function automatic logic [31:0] prow(input int r, input logic [7:0] k);
    logic [31:0] base;
    base = 32'h00010203 + 32'(r) * 32'h10101010;
    return base + {4{k}};
  endfunction

  function automatic logic [127:0] pexp(input logic [7:0] k);
    return EXP_BASE + {16{k}};
  endfunction

  task automatic put_row(input logic [31:0] r);
    in_valid = 1'b1;
    in_row   = r;
    tick();
  endtask

  task automatic put_block(input logic [7:0] k);
    for (int r = 0; r < 4; r++) put_row(prow(r, k));
  endtask

  task automatic put_dead();
    put_row(32'hdeadbeef);
    put_row(32'h01234567);
    put_row(32'h89abcdef);
    put_row(32'hcafef00d);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_row_idx",   128'(row_idx),   128'd0);
    check("rst_out_state", out_state,       128'd0);
    rst_n = 1'b1;
    tick();

    // Basic block
    out_ready = 1'b1;
    put_row(32'h00010203);
    put_row(32'h10111213);
    put_row(32'h20212223);
    check("basic_pre_valid", 128'(out_valid), 128'd0);
    put_row(32'h30313233);
    in_valid = 1'b0;
    check("basic_valid", 128'(out_valid), 128'd1);
    check("basic_state", out_state, EXP_BASE);
    check("basic_row_idx", 128'(row_idx), 128'd0);
    tick();
    check("basic_drain", 128'(out_valid), 128'd0);

    // Irregular row contents
    put_dead();
    in_valid = 1'b0;
    check("dead_state", out_state, EXP_DEAD);
    tick();

    // Backpressure: three blocks, only two fit
    out_ready = 1'b0;
    put_block(8'h40);
    put_block(8'h80);
    check("bp_in_ready_full", 128'(in_ready), 128'd0);
    check("bp_valid", 128'(out_valid), 128'd1);
    check("bp_state_a", out_state, pexp(8'h40));
    put_row(prow(0, 8'hc0));
    tick();
    check("bp_row_held", 128'(row_idx), 128'd0);
    check("bp_in_ready_held", 128'(in_ready), 128'd0);
    check("bp_state_stable", out_state, pexp(8'h40));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_state_b", out_state, pexp(8'h80));
    check("bp_row_not_taken", 128'(row_idx), 128'd0);
    check("bp_in_ready_free", 128'(in_ready), 128'd1);
    put_block(8'hc0);
    in_valid = 1'b0;
    check("bp_full_again", 128'(in_ready), 128'd0);
    check("bp_state_b_stable", out_state, pexp(8'h80));
    out_ready = 1'b1;
    tick();
    check("bp_state_c", out_state, pexp(8'hc0));
    check("bp_valid_c", 128'(out_valid), 128'd1);
    tick();
    check("bp_drained", 128'(out_valid), 128'd0);

    // Back-to-back streaming
    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r < 4; r++) begin
        put_row(prow(r, 8'(b * 16)));
        check("b2b_in_ready", 128'(in_ready), 128'd1);
        check("b2b_valid", 128'(out_valid), (r == 3) ? 128'd1 : 128'd0);
        if (r == 3) check("b2b_state", out_state, pexp(8'(b * 16)));
      end
    end
    in_valid = 1'b0;
    tick();
    check("b2b_drained", 128'(out_valid), 128'd0);

    // Flush keeps the completed block and drops the partial one
    out_ready = 1'b0;
    put_dead();
    put_row(prow(0, 8'h00));
    put_row(prow(1, 8'h00));
    flush = 1'b1;
    put_row(prow(2, 8'h00));
    flush = 1'b0;
    check("flush_row_idx", 128'(row_idx), 128'd0);
    put_block(8'h40);
    in_valid = 1'b0;
    check("flush_full", 128'(in_ready), 128'd0);
    check("flush_kept", out_state, EXP_DEAD);
    out_ready = 1'b1;
    tick();
    check("flush_clean", out_state, pexp(8'h40));
    check("flush_clean_valid", 128'(out_valid), 128'd1);
    tick();
    check("flush_drained", 128'(out_valid), 128'd0);

    // Asynchronous reset mid-block with a completed block pending
    out_ready = 1'b0;
    put_block(8'h80);
    put_row(prow(0, 8'h00));
    put_row(prow(1, 8'h00));
    in_valid = 1'b0;
    check("ar_pre_valid", 128'(out_valid), 128'd1);
    check("ar_pre_row_idx", 128'(row_idx), 128'd2);
    #3 rst_n = 1'b0;
    #1;
    check("ar_out_valid", 128'(out_valid), 128'd0);
    check("ar_in_ready", 128'(in_ready), 128'd1);
    check("ar_row_idx", 128'(row_idx), 128'd0);
    check("ar_out_state", out_state, 128'd0);
    #1 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    put_block(8'hc0);
    in_valid = 1'b0;
    check("ar_after_valid", 128'(out_valid), 128'd1);
    check("ar_after_state", out_state, pexp(8'hc0));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
